hwag_angle_sched: RTL and testbench



---
 rtl/hwag_angle_sched_if.sv | 26 ++
 rtl/hwag_angle_sched.sv | 200 ++++++++++++++++++++
 tb/tb_hwag_angle_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hwag_angle_sched_if.sv
// Configuration write channel of the angle scheduler.
// master drives valid/ch/start/stop/ena; slave returns ready and err.
interface hwag_angle_sched_if #(
  parameter int CH_SEL_WIDTH = 2,
  parameter int ANGLE_WIDTH  = 24
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CH_SEL_WIDTH-1:0] cfg_ch;
  logic [ANGLE_WIDTH-1:0]  cfg_start;
  logic [ANGLE_WIDTH-1:0]  cfg_stop;
  logic                    cfg_ena;
  logic                    cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_start,
    output cfg_stop, cfg_ena,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_start,
    input  cfg_stop, cfg_ena,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/hwag_angle_sched.sv
// Angle-window scheduler: CH_NUM start/stop windows, one shared
// comparator scanned round-robin, config double-buffered to wrap.
// Ports: clk, rst (sync, high), hwag_start, acnt, cfg (slave),
// ch_out, ch_pending; ch_limit when HWAG_ANGLE_SCHED_DWELL_LIMIT_EN.
module hwag_angle_sched #(
  parameter int CH_NUM       = 4,
  parameter int CH_SEL_WIDTH = 2,
  parameter int ANGLE_WIDTH  = 24,
  parameter int ANGLE_TOP    = 3839
`ifdef HWAG_ANGLE_SCHED_DWELL_LIMIT_EN
  , parameter int DWELL_MAX  = 65535
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] acnt,
  hwag_angle_sched_if.slave      cfg,
  output logic [CH_NUM-1:0]      ch_out,
  output logic [CH_NUM-1:0]      ch_pending
`ifdef HWAG_ANGLE_SCHED_DWELL_LIMIT_EN
  , output logic [CH_NUM-1:0]    ch_limit
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam int CH_PAD = 2 ** CH_SEL_WIDTH;
  localparam logic [ANGLE_WIDTH-1:0] TOP_A =
    ANGLE_WIDTH'(ANGLE_TOP);
  localparam logic [ANGLE_WIDTH-1:0] END_A =
    ANGLE_WIDTH'(ANGLE_TOP + 1);
  localparam logic [CH_SEL_WIDTH-1:0] PTR_LAST =
    CH_SEL_WIDTH'(CH_NUM - 1);

  state_e state_q, state_d;

  logic [ANGLE_WIDTH-1:0]  a_start_q [CH_NUM];
  logic [ANGLE_WIDTH-1:0]  a_stop_q  [CH_NUM];
  logic [ANGLE_WIDTH-1:0]  s_start_q [CH_NUM];
  logic [ANGLE_WIDTH-1:0]  s_stop_q  [CH_NUM];
  logic [CH_NUM-1:0]       a_ena_q, s_ena_q;
  logic [CH_NUM-1:0]       pend_q, out_q, out_d;
  logic [CH_SEL_WIDTH-1:0] ptr_q;
  logic [ANGLE_WIDTH-1:0]  acnt_prev_q;
  logic                    err_q;

  logic              run, scan, leave, wrap;
  logic              acc, ch_ok, rng_ok, wr_ok, win;
  logic [CH_PAD-1:0] pend_pad;
  logic [CH_NUM-1:0] trip;
  logic              blk_w;

  function automatic logic in_win(
    input logic                   ena,
    input logic [ANGLE_WIDTH-1:0] s,
    input logic [ANGLE_WIDTH-1:0] e,
    input logic [ANGLE_WIDTH-1:0] a
  );
    if (!ena)  return 1'b0;
    if (s < e) return (a >= s) && (a < e);
    if (s > e) return (a >= s) || (a < e);
    return 1'b0;
  endfunction

  assign run   = (state_q == RUN);
  assign scan  = run & hwag_start;
  assign leave = run & ~hwag_start;
  assign wrap  = run & (acnt < acnt_prev_q);

  // pad so an out-of-range cfg_ch indexes a zero bit
  assign pend_pad      = CH_PAD'(pend_q);
  assign cfg.cfg_ready = ~(run & pend_pad[cfg.cfg_ch]);
  assign cfg.cfg_err   = err_q;

  assign acc    = cfg.cfg_valid & cfg.cfg_ready;
  assign ch_ok  = (32'(cfg.cfg_ch) < CH_NUM);
  assign rng_ok = (cfg.cfg_start <= TOP_A) &&
                  (cfg.cfg_stop <= END_A);
  assign wr_ok  = acc & ch_ok & rng_ok;

  assign win = in_win(a_ena_q[ptr_q], a_start_q[ptr_q],
                      a_stop_q[ptr_q], acnt);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hwag_start)  state_d = RUN;
      RUN:     if (!hwag_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    out_d = out_q;
    if (scan) out_d[ptr_q] = win & ~blk_w;
    else      out_d = '0;
    out_d = out_d & ~trip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        a_start_q[i] <= '0;
        a_stop_q[i]  <= '0;
        s_start_q[i] <= '0;
        s_stop_q[i]  <= '0;
      end
      a_ena_q     <= '0;
      s_ena_q     <= '0;
      pend_q      <= '0;
      out_q       <= '0;
      ptr_q       <= '0;
      acnt_prev_q <= '0;
      err_q       <= 1'b0;
    end else begin
      acnt_prev_q <= acnt;
      err_q       <= acc & ~wr_ok;
      out_q       <= out_d;
      if (scan)
        ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      else
        ptr_q <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        if ((wrap | leave) && pend_q[i]) begin
          a_start_q[i] <= s_start_q[i];
          a_stop_q[i]  <= s_stop_q[i];
          a_ena_q[i]   <= s_ena_q[i];
          pend_q[i]    <= 1'b0;
        end
      end
      // a write on a wrap edge only reaches the shadow,
      // so it waits for the following wrap
      if (wr_ok) begin
        s_start_q[cfg.cfg_ch] <= cfg.cfg_start;
        s_stop_q[cfg.cfg_ch]  <= cfg.cfg_stop;
        s_ena_q[cfg.cfg_ch]   <= cfg.cfg_ena;
        if (scan) begin
          pend_q[cfg.cfg_ch]  <= 1'b1;
        end else begin
          a_start_q[cfg.cfg_ch] <= cfg.cfg_start;
          a_stop_q[cfg.cfg_ch]  <= cfg.cfg_stop;
          a_ena_q[cfg.cfg_ch]   <= cfg.cfg_ena;
        end
      end
    end
  end

`ifdef HWAG_ANGLE_SCHED_DWELL_LIMIT_EN
  localparam int DW = $clog2(DWELL_MAX + 1);
  localparam logic [DW-1:0] DW_MAX = DW'(DWELL_MAX);

  logic [DW-1:0]     dw_q [CH_NUM];
  logic [CH_NUM-1:0] lim_q, blk_q;

  always_comb begin
    trip = '0;
    for (int i = 0; i < CH_NUM; i++)
      trip[i] = out_q[i] & (dw_q[i] == DW_MAX);
  end

  assign blk_w = blk_q[ptr_q];

  // blocked channel re-arms only once the scanner sees it outside
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) dw_q[i] <= '0;
      lim_q <= '0;
      blk_q <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (!out_q[i] || trip[i]) dw_q[i] <= '0;
        else                      dw_q[i] <= dw_q[i] + 1'b1;
        if (trip[i]) begin
          blk_q[i] <= 1'b1;
          lim_q[i] <= 1'b1;
        end else if (scan && ptr_q == CH_SEL_WIDTH'(i) && !win) begin
          blk_q[i] <= 1'b0;
        end
        if (wr_ok && cfg.cfg_ch == CH_SEL_WIDTH'(i))
          lim_q[i] <= 1'b0;
      end
    end
  end

  assign ch_limit = lim_q;
`else
  assign trip  = '0;
  assign blk_w = 1'b0;
`endif

  assign ch_out     = out_q;
  assign ch_pending = pend_q;

endmodule

// File: tb/tb_hwag_angle_sched.sv
// Bench for hwag_angle_sched: window vector table, full-revolution
// sweep, and double-buffer / error / resync sequences.
module tb_hwag_angle_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        hwag_start;
  logic [23:0] acnt;
  logic [3:0]  ch_out, ch_pending;

  int checks   = 0;
  int failures = 0;

  bit         sb_q [$];
  logic [1:0] sw_q [$];

  hwag_angle_sched_if #(.CH_SEL_WIDTH(2), .ANGLE_WIDTH(24)) cif ();

  hwag_angle_sched #(
    .CH_NUM(4), .CH_SEL_WIDTH(2),
    .ANGLE_WIDTH(24), .ANGLE_TOP(3839)
  ) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start),
    .acnt(acnt), .cfg(cif),
    .ch_out(ch_out), .ch_pending(ch_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] s;
    logic [23:0] e;
    logic        en;
    logic [23:0] a;
    logic        exp;
  } vec_t;

  vec_t tv [13];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [23:0] s,
                    input logic [23:0] e, input logic en);
    bit ok = 0;
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = ch;
    cif.cfg_start = s;
    cif.cfg_stop  = e;
    cif.cfg_ena   = en;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (cif.cfg_ready) ok = 1;
      tick(1);
    end
    cif.cfg_valid = 1'b0;
    chk("wr_accept", ok, 1);
  endtask

  initial begin
    bit         eb;
    logic [1:0] e2;
    logic [23:0] a;

    tv[0]  = '{2'd0, 24'd100,  24'd200,  1'b1, 24'd99,   1'b0};
    tv[1]  = '{2'd0, 24'd100,  24'd200,  1'b1, 24'd100,  1'b1};
    tv[2]  = '{2'd0, 24'd100,  24'd200,  1'b1, 24'd199,  1'b1};
    tv[3]  = '{2'd0, 24'd100,  24'd200,  1'b1, 24'd200,  1'b0};
    tv[4]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd3800, 1'b1};
    tv[5]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd3839, 1'b1};
    tv[6]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd0,    1'b1};
    tv[7]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd39,   1'b1};
    tv[8]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd40,   1'b0};
    tv[9]  = '{2'd1, 24'd3800, 24'd40,   1'b1, 24'd3799, 1'b0};
    tv[10] = '{2'd2, 24'd500,  24'd500,  1'b1, 24'd500,  1'b0};
    tv[11] = '{2'd3, 24'd10,   24'd3840, 1'b1, 24'd3839, 1'b1};
    tv[12] = '{2'd2, 24'd0,    24'd100,  1'b0, 24'd50,   1'b0};

    rst = 1'b1;
    hwag_start = 1'b0;
    acnt = '0;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = '0;
    cif.cfg_start = '0;
    cif.cfg_stop = '0;
    cif.cfg_ena = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rst_out", ch_out, 0);
    chk("rst_pend", ch_pending, 0);
    chk("rst_err", cif.cfg_err, 0);
    chk("rst_ready", cif.cfg_ready, 1);

    foreach (tv[i]) begin
      hwag_start = 1'b0;
      tick(1);
      wr(tv[i].ch, tv[i].s, tv[i].e, tv[i].en);
      acnt = tv[i].a;
      hwag_start = 1'b1;
      sb_q.push_back(tv[i].exp);
      tick(6);
      eb = sb_q.pop_front();
      chk($sformatf("vec%0d", i), ch_out[tv[i].ch], eb);
    end

    hwag_start = 1'b0;
    tick(1);
    wr(2'd0, 24'd100, 24'd200, 1'b1);
    wr(2'd1, 24'd3800, 24'd40, 1'b1);
    acnt = '0;
    hwag_start = 1'b1;
    tick(1);
    for (int r = 0; r <= 3840; r++) begin
      a = 24'(r % 3840);
      acnt = a;
      sw_q.push_back({(a >= 3800 || a < 40),
                      (a >= 100 && a < 200)});
      tick(4);
      e2 = sw_q.pop_front();
      chk($sformatf("sweep%0d", a), ch_out[1:0], e2);
      tick(4);
    end

    hwag_start = 1'b0;
    tick(1);
    acnt = 24'd150;
    hwag_start = 1'b1;
    tick(6);
    chk("a_old_on", ch_out[0], 1);
    wr(2'd0, 24'd500, 24'd600, 1'b1);
    chk("a_pend_set", ch_pending, 4'b0001);
    cif.cfg_valid = 1'b1;
    cif.cfg_ch = 2'd0;
    cif.cfg_start = 24'd700;
    cif.cfg_stop = 24'd800;
    #1;
    chk("a_stall_rdy", cif.cfg_ready, 0);
    tick(3);
    chk("a_stall_pend", ch_pending, 4'b0001);
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = 2'd1;
    #1;
    chk("a_rdy_ch1", cif.cfg_ready, 1);
    chk("a_old_hold", ch_out[0], 1);
    acnt = 24'd3000;
    tick(6);
    chk("a_old_off", ch_out[0], 0);
    chk("a_pend_hold", ch_pending[0], 1);
    acnt = 24'd550;
    tick(6);
    chk("a_commit", ch_pending[0], 0);
    chk("a_new_on", ch_out[0], 1);

    wr(2'd0, 24'd3840, 24'd10, 1'b1);
    chk("b_err_hi", cif.cfg_err, 1);
    tick(1);
    chk("b_err_lo", cif.cfg_err, 0);
    chk("b_pend", ch_pending, 0);
    wr(2'd0, 24'd10, 24'd3841, 1'b1);
    chk("b_err2", cif.cfg_err, 1);
    tick(6);
    chk("b_win_kept", ch_out[0], 1);

    wr(2'd0, 24'd700, 24'd800, 1'b1);
    chk("c_pend", ch_pending[0], 1);
    hwag_start = 1'b0;
    tick(1);
    chk("c_out_clr", ch_out, 0);
    chk("c_pend_clr", ch_pending, 0);
    acnt = 24'd750;
    hwag_start = 1'b1;
    tick(6);
    chk("c_resync", ch_out[0], 1);

    acnt = 24'd100;
    wr(2'd0, 24'd900, 24'd1000, 1'b1);
    chk("d_pend", ch_pending[0], 1);
    tick(6);
    chk("d_off", ch_out[0], 0);
    acnt = 24'd950;
    tick(6);
    chk("d_not_yet", ch_out[0], 0);
    chk("d_pend2", ch_pending[0], 1);
    acnt = 24'd10;
    tick(6);
    chk("d_commit", ch_pending[0], 0);
    acnt = 24'd950;
    tick(6);
    chk("d_on", ch_out[0], 1);

    wr(2'd2, 24'd1, 24'd2, 1'b1);
    chk("e_pend", ch_pending[2], 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("e_out", ch_out, 0);
    chk("e_pend_clr", ch_pending, 0);
    hwag_start = 1'b1;
    tick(6);
    chk("e_cfg_lost", ch_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
